msrr_deserializer: RTL and testbench
====================================

Name: msrr_deserializer

Overview:
- Serial-in/parallel-out receiver: the far end of the 8-bit multi-mode shift register's serial output.
- Reassembles a WIDTH-bit word from a bit stream, shifted right (LSB-first) or left (MSB-first).
- Presents the word on PO with a valid/ready handshake and flags overruns.
- Sits between a serial link and a parallel consumer, in the same clock domain as the transmitting shift register.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin a frame; sampled only in IDLE.
- dir  input  1  frame bit order, latched at start: 0 = LSB-first (shift-right source), 1 = MSB-first (shift-left source).
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a valid bit this cycle.
- PO  output  WIDTH  assembled parallel word.
- po_valid  output  1  PO holds an unconsumed word.
- po_ready  input  1  consumer accepts PO.
- busy  output  1  frame in progress (state is not IDLE).
- overrun  output  1  sticky: a completed word was dropped.
- parity_err  output  1  parity result for the word in PO (see Optional Feature).

Behaviour:
- Reset (async, rst=1), all outputs and internal state clear immediately:
  - PO=0, po_valid=0, busy=0, overrun=0, parity_err=0.
  - shift register=0, bit count=0, state=IDLE.
- Reset asserted mid-frame discards the partial word.
- States and transitions:
  - IDLE: start=1 at a clock edge latches dir into dir_q, clears the shift register and count, and moves to SHIFT. busy=1 from the next cycle.
  - SHIFT: every edge with sin_valid=1 accepts one bit and increments the count. Edges with sin_valid=0 change nothing; gaps of any length are legal.
  - SHIFT, dir_q=0: sr <= {sin, sr[WIDTH-1:1]}.
  - SHIFT, dir_q=1: sr <= {sr[WIDTH-2:0], sin}.
  - SHIFT completion: on the edge accepting bit WIDTH (count == WIDTH-1 with sin_valid=1), the finished word is delivered (below) and state returns to IDLE. With PARITY_CHECK_EN the state moves to PAR instead.
  - start is ignored outside IDLE. A new frame can start on the cycle after returning to IDLE.
- Delivery:
  - Latency: PO and po_valid update at the same edge that accepts the last bit, so they are visible one cycle after that bit is presented.
  - If po_valid=0, or po_valid=1 and po_ready=1 at that edge: PO <= word and po_valid=1.
  - If po_valid=1 and po_ready=0 at that edge: the word is dropped, PO is kept, and overrun <= 1. overrun stays set until reset.
- Handshake: po_valid clears on an edge with po_valid=1 and po_ready=1 when no new word is delivered at that edge. PO holds its value while po_valid=0.
- Counter width is $clog2(WIDTH+1); the count never wraps past WIDTH.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - After WIDTH data bits the block enters PAR and accepts one extra valid bit, the even-parity bit.
  - Delivery and the overrun rules then happen on the edge that accepts the parity bit, not the last data bit.
  - parity_err is loaded alongside PO with (^word) ^ parity_bit.
  - A dropped word leaves parity_err unchanged.
- Undefined: PAR state is absent, frames are WIDTH bits, and parity_err is tied 0.

Decomposition:
- Package msrr_pkg:
  - state enum state_t {IDLE, SHIFT, PAR}.
  - DIR_LSB_FIRST=1'b0 and DIR_MSB_FIRST=1'b1.
  - default width constant MSRR_W=8.
- Sub-module msrr_sipo_core: the directional shift register plus bit counter, with inputs clear, shift_en, dir, sin and outputs word and last_bit.
- The top level holds the FSM, the output register, the handshake and the overrun logic.

Test Plan:
- LSB-first: start with dir=0, bits 1,0,1,0,0,1,0,1 on consecutive cycles, po_ready=1 → PO=8'hA5 and po_valid=1 one cycle after the 8th bit; busy falls at the same time; overrun=0.
- MSB-first with gaps: dir=1, bits 0,0,1,1,1,1,0,0 with sin_valid low for 2 cycles after bits 3 and 6 → PO=8'h3C, with no extra bits captured during the gaps.
- Overrun: po_ready=0, two frames 8'h0F then 8'hF0 → PO stays 8'h0F, po_valid=1, overrun=1; overrun remains 1 after po_ready=1 consumes the word.
- Simultaneous: hold po_ready=1 with a pending 8'h11 exactly on the last-bit edge of 8'h22 → PO=8'h22, po_valid stays 1, overrun=0.
- Reset mid-frame: 3 bits into a frame, pulse rst asynchronously (between edges) → all outputs 0 immediately; the next full frame 8'h5A is received correctly.
- PARITY_CHECK_EN: frame 8'hA5 (dir=0) plus parity bit 1 → PO=8'hA5, parity_err=1; repeated with parity bit 0 → parity_err=0.

Source files
------------

// File: rtl/msrr_pkg.sv
// msrr_pkg: shared state encoding, bit-order constants and default width for the deserializer
package msrr_pkg;
  localparam int MSRR_W = 8;
  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
endpackage

// File: rtl/msrr_sipo_core.sv
// msrr_sipo_core: directional shift register plus saturating bit counter
module msrr_sipo_core import msrr_pkg::*; #(
  parameter int WIDTH = MSRR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             sin,
  output logic [WIDTH-1:0] word,
  output logic             last_bit
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  // word already includes the bit accepted this cycle, so the top can deliver on the same edge
  assign word = shift_en ? (dir == DIR_MSB_FIRST ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]}) : sr;
  assign last_bit = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= word;
      cnt <= cnt == CW'(WIDTH) ? cnt : cnt + 1'b1;
    end
endmodule

// File: rtl/msrr_deserializer.sv
// msrr_deserializer: serial-in/parallel-out receiver with valid/ready output and sticky overrun
// Define PARITY_CHECK_EN to accept a trailing even-parity bit per frame and report parity_err.
module msrr_deserializer import msrr_pkg::*; #(
  parameter int WIDTH = MSRR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] PO,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);
  state_t state, state_n;
  logic dir_q, clear, shift_en, last_bit, deliver, par_calc;
  logic [WIDTH-1:0] word;
`ifdef PARITY_CHECK_EN
  localparam state_t DATA_DONE = PAR;
  assign deliver  = state == PAR && sin_valid;
  assign par_calc = ^word ^ sin;
`else
  localparam state_t DATA_DONE = IDLE;
  assign deliver  = shift_en && last_bit;
  assign par_calc = 1'b0;
`endif
  assign clear    = state == IDLE && start;
  assign shift_en = state == SHIFT && sin_valid;
  assign busy     = state != IDLE;
  msrr_sipo_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (shift_en),
    .dir      (dir_q),
    .sin      (sin),
    .word     (word),
    .last_bit (last_bit)
  );
  always_comb
    state_n = clear ? SHIFT :
              (shift_en && last_bit) ? DATA_DONE :
              (state == PAR && sin_valid) ? IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dir_q      <= DIR_LSB_FIRST;
      PO         <= '0;
      po_valid   <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (clear) dir_q <= dir;
      if (deliver && (!po_valid || po_ready)) begin
        PO         <= word;
        po_valid   <= 1'b1;
        parity_err <= par_calc;
      end else if (deliver) overrun <= 1'b1;
      else if (po_valid && po_ready) po_valid <= 1'b0;
    end
endmodule

// File: tb/tb_msrr_deserializer.sv
// tb_msrr_deserializer: directed and randomized frames checked against a word-level delivery model
module tb_msrr_deserializer;
  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk = 0, rst = 1, start = 0, dir = 0, sin = 0, sin_valid = 0, po_ready = 0;
  logic [W-1:0] PO;
  logic po_valid, busy, overrun, parity_err;
  int nvec = 0, nerr = 0;
  logic [W-1:0] mpo = '0;
  logic mv = 0, movr = 0, mpe = 0;

  msrr_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .sin(sin), .sin_valid(sin_valid),
    .PO(PO), .po_valid(po_valid), .po_ready(po_ready), .busy(busy),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // Drives one frame starting at a negedge; the model applies the delivery rules at frame level.
  task automatic send(input logic [W-1:0] w, input logic d, input logic rdy, input logic rdy_last,
                      input logic pb, input int gapmax, input logic [W:0] gapmask);
    int g;
    po_ready = rdy;
    @(negedge clk); start = 1; dir = d;
    @(negedge clk); start = 0; dir = ~d;
    if (mv && rdy) mv = 0;
    for (int i = 0; i < W + PB; i++) begin
      g = gapmask[i] ? 2 : (gapmax > 0 ? int'($urandom_range(gapmax, 0)) : 0);
      repeat (g) begin sin_valid = 0; sin = 1'($urandom); @(negedge clk); end
      sin = i < W ? (d ? w[W-1-i] : w[i]) : pb;
      sin_valid = 1;
      if (i == W + PB - 1) po_ready = rdy_last;
      @(negedge clk);
    end
    sin_valid = 0;
    sin = 1'($urandom);
    if (!mv || rdy_last) begin
      mpo = w; mv = 1; mpe = (PB == 1) ? (^w ^ pb) : 1'b0;
    end else movr = 1;
  endtask

  task automatic test_reset;
    #1;
    nvec++; if ({PO, po_valid, busy, overrun, parity_err} !== '0) begin nerr++; $display("FAIL reset outputs got %h exp 0", {PO, po_valid, busy, overrun, parity_err}); end
    @(negedge clk); rst = 0;
    mpo = '0; mv = 0; movr = 0; mpe = 0;
  endtask

  task automatic test_lsb;
    send(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 0, '0);
    nvec++; if (PO !== 8'hA5) begin nerr++; $display("FAIL lsb PO got %h exp a5", PO); end
    nvec++; if (po_valid !== 1'b1) begin nerr++; $display("FAIL lsb po_valid got %b exp 1", po_valid); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL lsb busy got %b exp 0", busy); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL lsb overrun got %b exp 0", overrun); end
    nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL lsb parity_err got %b exp 0", parity_err); end
  endtask

  task automatic test_msb_gaps;
    send(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 0, 9'b001001000);
    nvec++; if (PO !== 8'h3C) begin nerr++; $display("FAIL msb_gaps PO got %h exp 3c", PO); end
    nvec++; if (po_valid !== 1'b1) begin nerr++; $display("FAIL msb_gaps po_valid got %b exp 1", po_valid); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL msb_gaps busy got %b exp 0", busy); end
  endtask

  task automatic test_simultaneous;
    send(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 0, '0);
    nvec++; if (PO !== 8'h11) begin nerr++; $display("FAIL simul_first PO got %h exp 11", PO); end
    send(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0);
    nvec++; if (PO !== 8'h22) begin nerr++; $display("FAIL simul PO got %h exp 22", PO); end
    nvec++; if (po_valid !== 1'b1) begin nerr++; $display("FAIL simul po_valid got %b exp 1", po_valid); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL simul overrun got %b exp 0", overrun); end
  endtask

  task automatic test_overrun;
    send(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 0, '0);
    send(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0);
    nvec++; if (PO !== 8'h0F) begin nerr++; $display("FAIL overrun PO got %h exp 0f", PO); end
    nvec++; if (po_valid !== 1'b1) begin nerr++; $display("FAIL overrun po_valid got %b exp 1", po_valid); end
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL overrun flag got %b exp 1", overrun); end
    po_ready = 1;
    @(negedge clk);
    mv = 0;
    nvec++; if (po_valid !== 1'b0) begin nerr++; $display("FAIL consume po_valid got %b exp 0", po_valid); end
    nvec++; if (overrun !== 1'b1) begin nerr++; $display("FAIL sticky overrun got %b exp 1", overrun); end
    nvec++; if (PO !== 8'h0F) begin nerr++; $display("FAIL consume PO hold got %h exp 0f", PO); end
  endtask

  task automatic test_reset_midframe;
    logic [W-1:0] w;
    w = 8'hC3;
    po_ready = 0;
    @(negedge clk); start = 1; dir = 0;
    @(negedge clk); start = 0;
    for (int i = 0; i < 3; i++) begin sin = w[i]; sin_valid = 1; @(negedge clk); end
    sin_valid = 0;
    #1 rst = 1;
    #1;
    nvec++; if ({PO, po_valid, busy, overrun, parity_err} !== '0) begin nerr++; $display("FAIL async_reset outputs got %h exp 0", {PO, po_valid, busy, overrun, parity_err}); end
    #1 rst = 0;
    mpo = '0; mv = 0; movr = 0; mpe = 0;
    send(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 0, '0);
    nvec++; if (PO !== 8'h5A) begin nerr++; $display("FAIL post_reset PO got %h exp 5a", PO); end
    nvec++; if (po_valid !== 1'b1) begin nerr++; $display("FAIL post_reset po_valid got %b exp 1", po_valid); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL post_reset overrun got %b exp 0", overrun); end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity;
    send(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 0, '0);
    nvec++; if (PO !== 8'hA5) begin nerr++; $display("FAIL parity1 PO got %h exp a5", PO); end
    nvec++; if (parity_err !== 1'b1) begin nerr++; $display("FAIL parity1 parity_err got %b exp 1", parity_err); end
    send(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 0, '0);
    nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL parity0 parity_err got %b exp 0", parity_err); end
  endtask
`endif

  task automatic test_random;
    logic [W-1:0] w;
    for (int f = 0; f < 40; f++) begin
      w = W'($urandom);
      send(w, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3, '0);
      nvec++; if (PO !== mpo) begin nerr++; $display("FAIL rand[%0d] PO got %h exp %h", f, PO, mpo); end
      nvec++; if (po_valid !== mv) begin nerr++; $display("FAIL rand[%0d] po_valid got %b exp %b", f, po_valid, mv); end
      nvec++; if (overrun !== movr) begin nerr++; $display("FAIL rand[%0d] overrun got %b exp %b", f, overrun, movr); end
      nvec++; if (parity_err !== mpe) begin nerr++; $display("FAIL rand[%0d] parity_err got %b exp %b", f, parity_err, mpe); end
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rand[%0d] busy got %b exp 0", f, busy); end
    end
  endtask

  initial begin
    test_reset;
    test_lsb;
    test_msb_gaps;
    test_simultaneous;
    test_overrun;
    test_reset_midframe;
`ifdef PARITY_CHECK_EN
    test_parity;
`endif
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
